pc_add: RTL and testbench

Next-PC computation unit for the single-cycle/multi-cycle MIPS datapath. It sits between the PC register and the instruction fetch stage. From the current PC, the sign-extended immediate, the 26-bit jump field and the rs register value, it selects the address of the next instruction according to `PCSrc`. The result is registered on `CLK`; the block also flags misaligned register-jump targets.

---
 rtl/pc_add.sv | 74 +++++++
 tb/tb_pc_add.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pc_add.sv
// Next-PC unit: sequential, branch, jump and jump-register targets.
// Registered next PC plus a misaligned-target flag, one-cycle latency.
//
// Ports:
//   CLK       rising-edge clock
//   RST       synchronous active-high reset
//   PCSrc     00 seq, 01 branch, 10 J/JAL, 11 JR
//   curPC     current instruction address
//   immediate sign-extended word offset
//   addr      J/JAL instruction index
//   rs        JR register value
//   nextPC    registered next address
//   alignErr  registered, nextPC[1:0] != 0
module pc_add (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] curPC,
  input  logic [31:0] immediate,
  input  logic [25:0] addr,
  input  logic [31:0] rs,
  output logic [31:0] nextPC,
  output logic        alignErr
);

  logic [31:0] pc4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] tgt;
  logic        err;

  logic [31:0] next_pc_d, next_pc_q;
  logic        align_err_d, align_err_q;

  // The shift drops immediate[31:30]; the
  // sign survives through 32-bit wrap.
  always_comb begin
    pc4    = curPC + 32'd4;
    br_tgt = pc4 + (immediate << 2);
    j_tgt  = {pc4[31:28], addr, 2'b00};
  end

  always_comb begin
    tgt = pc4;
    unique case (PCSrc)
      2'b00: tgt = pc4;
      2'b01: tgt = br_tgt;
      2'b10: tgt = j_tgt;
      2'b11: tgt = rs;
    endcase
  end

  // Only reported, never trapped.
  assign err = |tgt[1:0];

  always_comb begin
    next_pc_d   = tgt;
    align_err_d = err;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      next_pc_q   <= 32'h0;
      align_err_q <= 1'b0;
    end else begin
      next_pc_q   <= next_pc_d;
      align_err_q <= align_err_d;
    end
  end

  assign nextPC   = next_pc_q;
  assign alignErr = align_err_q;

endmodule

// File: tb/tb_pc_add.sv
// Bench for pc_add: directed steps then random
// stimulus against an arithmetic reference model.
module tb_pc_add;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  PCSrc;
  logic [31:0] curPC;
  logic [31:0] immediate;
  logic [25:0] addr;
  logic [31:0] rs;
  logic [31:0] nextPC;
  logic        alignErr;

  int passed = 0;
  int total  = 0;

  pc_add dut (
    .CLK       (CLK),
    .RST       (RST),
    .PCSrc     (PCSrc),
    .curPC     (curPC),
    .immediate (immediate),
    .addr      (addr),
    .rs        (rs),
    .nextPC    (nextPC),
    .alignErr  (alignErr)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Reference: plain arithmetic from the architectural rules.
  function automatic logic [31:0] ref_tgt(
    input logic [1:0]  src,
    input logic [31:0] pc,
    input logic [31:0] imm,
    input logic [25:0] a,
    input logic [31:0] r);
    logic [31:0] p4;
    logic [31:0] ax;
    p4 = pc + 32'd4;
    ax = {6'd0, a};
    case (src)
      2'd0:    return p4;
      2'd1:    return p4 + imm * 32'd4;
      2'd2:    return (p4 & 32'hF000_0000) | (ax * 32'd4);
      default: return r;
    endcase
  endfunction

  task automatic go(input string tag,
                    input logic [31:0] pc_e,
                    input logic err_e);
    step();
    chk({tag, ".pc"}, nextPC, pc_e);
    chk({tag, ".err"}, {31'd0, alignErr}, {31'd0, err_e});
  endtask

  initial begin
    logic [31:0] e;
    logic        rst_r;
    RST = 1'b1;
    PCSrc = 2'b00;
    curPC = 32'h40;
    immediate = 32'h0;
    addr = 26'h0;
    rs = 32'h0;

    go("rst1", 32'h0, 1'b0);
    go("rst2", 32'h0, 1'b0);
    RST = 1'b0;
    go("rel", 32'h44, 1'b0);

    curPC = 32'h0;        go("seq0", 32'h4, 1'b0);
    curPC = 32'h4;        go("seq4", 32'h8, 1'b0);
    curPC = 32'h8;        go("seq8", 32'hC, 1'b0);
    curPC = 32'hFFFF_FFFC; go("wrap", 32'h0, 1'b0);

    PCSrc = 2'b01;
    curPC = 32'h100;
    immediate = 32'h3;    go("brf", 32'h110, 1'b0);
    immediate = 32'hFFFF_FFFE; go("brb", 32'hFC, 1'b0);
    immediate = 32'hFFFF_FFFF; go("brm1", 32'h100, 1'b0);

    PCSrc = 2'b10;
    curPC = 32'h4000_0000;
    addr = 26'h10;        go("j", 32'h4000_0040, 1'b0);
    curPC = 32'h0FFF_FFFC;
    addr = 26'h0;         go("jreg", 32'h1000_0000, 1'b0);

    PCSrc = 2'b11;
    rs = 32'h0040_0020;   go("jr", 32'h0040_0020, 1'b0);
    rs = 32'h0040_0022;   go("jrmis", 32'h0040_0022, 1'b1);

    PCSrc = 2'b00;
    curPC = 32'h2;        go("pcmis", 32'h6, 1'b1);

    PCSrc = 2'b11;
    rs = 32'h1;
    RST = 1'b1;           go("midrst", 32'h0, 1'b0);
    RST = 1'b0;           go("after", 32'h1, 1'b1);

    for (int i = 0; i < 200; i++) begin
      rst_r = ($urandom_range(0, 15) == 0);
      RST = rst_r;
      PCSrc = 2'($urandom_range(0, 3));
      curPC = $urandom;
      if ($urandom_range(0, 7) != 0)
        curPC = curPC & 32'hFFFF_FFFC;
      immediate = $urandom;
      addr = 26'($urandom);
      rs = $urandom;
      if ($urandom_range(0, 1) == 0)
        rs = rs & 32'hFFFF_FFFC;
      e = ref_tgt(PCSrc, curPC, immediate, addr, rs);
      if (rst_r) e = 32'h0;
      go("rnd", e, (e % 32'd4) != 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
